// File: rtl/arm_pkg.sv
// arm_pkg: definitions shared across the ARM datapath blocks.
//   mul_state_t : control states of the iterative multiplier
//   REG_PC      : register-file address of r15 (program counter)
package arm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   localparam logic [3:0] REG_PC = 4'hF;

endpackage

// File: rtl/mul_unit.sv
// mul_unit: radix-2 iterative shift-add multiplier for MUL / MLA.
// One multiplier bit is consumed per RUN cycle; with EARLY_TERM=1 the
// iteration stops as soon as the remaining multiplier bits are all zero.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   start   request, sampled only in IDLE
//   acc     1 = MLA (accumulate c), 0 = MUL
//   a       multiplicand (Rm)
//   b       multiplier (Rs)
//   c       accumulator operand (Rn), used when acc=1
//   rd      destination register
//   busy    high while iterating (RUN)
//   done    one-cycle pulse, result valid
//   we      register-file write enable, pulses with done unless wa is the PC
//   wa      destination address, captured at start
//   result  low WIDTH bits of a*b (+c), held until the next completion
//   n_flag  result[WIDTH-1]
//   z_flag  result == 0
module mul_unit #(
   parameter int WIDTH      = 32,
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             acc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [3:0]       rd,
   output logic             busy,
   output logic             done,
   output logic             we,
   output logic [3:0]       wa,
   output logic [WIDTH-1:0] result,
   output logic             n_flag,
   output logic             z_flag
);

   import arm_pkg::*;

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   mul_state_t       state;
   mul_state_t       state_nxt;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] accum;
   logic [CNT_W-1:0] count;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] mplier_sh;
   logic             last;
   logic             load;

   // Single adder: partial product add for the current multiplier bit.
   always_comb begin
      sum       = accum + (mplier[0] ? mcand : '0);
      mplier_sh = mplier >> 1;
      // Terminate on the final bit position, or early once nothing is left.
      last      = (count == LAST_CNT) || (EARLY_TERM && (mplier_sh == '0));
      load      = (state == IDLE) && start;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Iteration datapath; no reset needed, always loaded before use.
   always_ff @(posedge clk) begin
      if (load) begin
         mcand  <= a;
         mplier <= b;
         accum  <= acc ? c : '0;
         count  <= '0;
      end else if (state == RUN) begin
         accum  <= sum;
         mcand  <= mcand << 1;
         mplier <= mplier_sh;
         count  <= count + CNT_W'(1);
      end
   end

   // Architecturally visible registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wa     <= '0;
         result <= '0;
         n_flag <= 1'b0;
         z_flag <= 1'b0;
      end else begin
         if (load) begin
            wa <= rd;
         end
         // Capture the final sum on the last iteration so it is already
         // registered for the done cycle.
         if ((state == RUN) && last) begin
            result <= sum;
            n_flag <= sum[WIDTH-1];
            z_flag <= (sum == '0);
         end
      end
   end

   // Outputs decode registered state only; no input-to-output path.
   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign we   = (state == DONE) && (wa != REG_PC);

endmodule

// File: tb/tb_mul_unit.sv
module tb_mul_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start1, start0;
   logic        acc;
   logic [31:0] a, b, c;
   logic [3:0]  rd;

   logic        busy1, done1, we1, n1, z1;
   logic [3:0]  wa1;
   logic [31:0] result1;
   logic        busy0, done0, we0, n0, z0;
   logic [3:0]  wa0;
   logic [31:0] result0;

   int          sel;
   logic        busy_s, done_s, we_s, n_s, z_s;
   logic [3:0]  wa_s;
   logic [31:0] result_s;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] res;
      logic        we;
      logic [3:0]  wa;
      int          n;
   } exp_t;

   exp_t sb[$];

   mul_unit #(.WIDTH(32), .EARLY_TERM(1'b1)) u_et1 (
      .clk(clk), .reset(reset), .start(start1), .acc(acc),
      .a(a), .b(b), .c(c), .rd(rd),
      .busy(busy1), .done(done1), .we(we1), .wa(wa1),
      .result(result1), .n_flag(n1), .z_flag(z1)
   );

   mul_unit #(.WIDTH(32), .EARLY_TERM(1'b0)) u_et0 (
      .clk(clk), .reset(reset), .start(start0), .acc(acc),
      .a(a), .b(b), .c(c), .rd(rd),
      .busy(busy0), .done(done0), .we(we0), .wa(wa0),
      .result(result0), .n_flag(n0), .z_flag(z0)
   );

   always #5 clk = ~clk;

   always_comb begin
      if (sel == 1) begin
         busy_s = busy1; done_s = done1; we_s = we1; wa_s = wa1;
         result_s = result1; n_s = n1; z_s = z1;
      end else begin
         busy_s = busy0; done_s = done0; we_s = we0; wa_s = wa0;
         result_s = result0; n_s = n0; z_s = z0;
      end
   end

   function automatic int model_iters(input logic [31:0] bv, input bit et);
      int m;
      m = 0;
      if (!et) return 32;
      for (int i = 0; i < 32; i++)
         if (bv[i]) m = i + 1;
      return (m == 0) ? 1 : m;
   endfunction

   // Drive one request; leaves the bench at the negedge after the start edge.
   task automatic issue(input bit et, input logic [31:0] ai, input logic [31:0] bi,
                        input logic [31:0] ci, input logic accv, input logic [3:0] rdv);
      exp_t e;
      logic [63:0] prod;
      sel = et ? 1 : 0;
      prod  = {32'd0, ai} * {32'd0, bi};
      e.res = prod[31:0] + (accv ? ci : 32'd0);
      e.we  = (rdv != 4'hF);
      e.wa  = rdv;
      e.n   = model_iters(bi, et);
      sb.push_back(e);
      @(negedge clk);
      a = ai; b = bi; c = ci; acc = accv; rd = rdv;
      if (et) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start0 = 1'b0;
   endtask

   // Count RUN cycles, then compare the completion against the scoreboard.
   // With hammer set, start is held high with fresh operands throughout RUN.
   task automatic collect(input string name, input bit hammer);
      exp_t        e;
      int          cycles;
      logic [31:0] held;
      cycles = 0;
      while (busy_s === 1'b1 && cycles < 200) begin
         if (hammer) begin
            a = $urandom; b = $urandom; c = $urandom; rd = 4'($urandom);
            acc = 1'b1;
            if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
         end
         cycles++;
         @(negedge clk);
      end
      start1 = 1'b0; start0 = 1'b0;
      e = sb.pop_front();
      checks++;
      if (cycles != e.n) begin
         errors++; $display("FAIL %s run_cycles got=%0d exp=%0d", name, cycles, e.n);
      end
      checks++;
      if (done_s !== 1'b1) begin
         errors++; $display("FAIL %s done got=%b exp=1", name, done_s);
      end
      checks++;
      if (busy_s !== 1'b0) begin
         errors++; $display("FAIL %s busy_with_done got=%b exp=0", name, busy_s);
      end
      checks++;
      if (result_s !== e.res) begin
         errors++; $display("FAIL %s result got=%h exp=%h", name, result_s, e.res);
      end
      checks++;
      if (we_s !== e.we) begin
         errors++; $display("FAIL %s we got=%b exp=%b", name, we_s, e.we);
      end
      checks++;
      if (wa_s !== e.wa) begin
         errors++; $display("FAIL %s wa got=%h exp=%h", name, wa_s, e.wa);
      end
      checks++;
      if (n_s !== e.res[31]) begin
         errors++; $display("FAIL %s n_flag got=%b exp=%b", name, n_s, e.res[31]);
      end
      checks++;
      if (z_s !== (e.res == 32'd0)) begin
         errors++; $display("FAIL %s z_flag got=%b exp=%b", name, z_s, (e.res == 32'd0));
      end
      held = e.res;
      @(negedge clk);
      checks++;
      if (done_s !== 1'b0 || we_s !== 1'b0) begin
         errors++; $display("FAIL %s pulse_end done=%b we=%b exp=0", name, done_s, we_s);
      end
      checks++;
      if (result_s !== held) begin
         errors++; $display("FAIL %s result_hold got=%h exp=%h", name, result_s, held);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({busy1, done1, we1, wa1, result1, n1, z1} !== '0 ||
          {busy0, done0, we0, wa0, result0, n0, z0} !== '0) begin
         errors++;
         $display("FAIL %s outputs_zero et1: busy=%b done=%b we=%b wa=%h res=%h n=%b z=%b et0: busy=%b done=%b we=%b wa=%h res=%h n=%b z=%b exp all 0",
                  name, busy1, done1, we1, wa1, result1, n1, z1,
                  busy0, done0, we0, wa0, result0, n0, z0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start1 = 1'b0; start0 = 1'b0;
      acc = 1'b0; a = '0; b = '0; c = '0; rd = '0; sel = 1;
      #1;
      check_all_zero("reset_initial");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset_released_idle");
   endtask

   task automatic test_mul();
      issue(1'b1, 32'd7, 32'd6, 32'd0, 1'b0, 4'd3);
      collect("mul_7x6", 1'b0);
      issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd1);
      collect("mul_ff_x_ff", 1'b0);
      issue(1'b0, 32'd5, 32'd3, 32'd0, 1'b0, 4'd2);
      collect("mul_5x3_noet", 1'b0);
      issue(1'b1, 32'h0001_2345, 32'h0000_0A0B, 32'd0, 1'b0, 4'd9);
      collect("mul_mixed", 1'b0);
      issue(1'b1, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 4'd4);
      collect("mul_neg_result", 1'b0);
   endtask

   task automatic test_mla();
      issue(1'b1, 32'd3, 32'd4, 32'hFFFF_FFF4, 1'b1, 4'd6);
      collect("mla_zero", 1'b0);
      issue(1'b0, 32'd10, 32'd10, 32'd23, 1'b1, 4'd7);
      collect("mla_noet", 1'b0);
   endtask

   task automatic test_b_zero();
      issue(1'b1, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 4'd8);
      collect("mul_b_zero", 1'b0);
   endtask

   task automatic test_start_ignored();
      int extra;
      issue(1'b1, 32'd7, 32'd6, 32'd0, 1'b0, 4'd5);
      collect("start_hammer", 1'b1);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         if (done1 === 1'b1) extra++;
         @(negedge clk);
      end
      checks++;
      if (extra != 0) begin
         errors++; $display("FAIL start_hammer extra_done got=%0d exp=0", extra);
      end
   endtask

   task automatic test_reset_mid_run();
      int dones;
      sel = 1;
      @(negedge clk);
      a = 32'd9; b = 32'h8000_0000; c = '0; acc = 1'b0; rd = 4'd5;
      start1 = 1'b1; start0 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start0 = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy1 !== 1'b1 || busy0 !== 1'b1) begin
         errors++; $display("FAIL reset_mid_run busy_before got=%b%b exp=11", busy1, busy0);
      end
      #2 reset = 1'b1;
      #1;
      check_all_zero("reset_mid_run_async");
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (done1 === 1'b1 || we1 === 1'b1 || done0 === 1'b1 || we0 === 1'b1) dones++;
         @(negedge clk);
      end
      checks++;
      if (dones != 0) begin
         errors++; $display("FAIL reset_mid_run aborted_write got=%0d exp=0", dones);
      end
      issue(1'b1, 32'd2, 32'd2, 32'd0, 1'b0, 4'd1);
      collect("after_reset_2x2", 1'b0);
   endtask

   task automatic test_pc_dest();
      issue(1'b1, 32'd2, 32'd3, 32'd0, 1'b0, 4'hF);
      collect("pc_dest", 1'b0);
      issue(1'b0, 32'd2, 32'd3, 32'd0, 1'b0, 4'hF);
      collect("pc_dest_noet", 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         issue(i[0], $urandom, $urandom, $urandom, 1'($urandom), 4'($urandom));
         collect("back_to_back", 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mla();
      test_b_zero();
      test_start_ignored();
      test_reset_mid_run();
      test_pc_dest();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative shift-add multiplier for the single-cycle ARM datapath, executing MUL and MLA. It sits directly downstream of the register file: it takes the two read-port values and the accumulator operand, and stalls the core while it computes. It then presents a 32-bit result, destination address and write-enable for the register file's write port. Radix-2, one multiplier bit per cycle, with optional early termination.

## Interface
Parameters:
- WIDTH, 32, operand and result width
- EARLY_TERM, 1, 1 = stop iterating once the remaining multiplier bits are all zero; 0 = always run WIDTH iterations

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- acc  input  1  1 = MLA (add c), 0 = MUL
- a  input  WIDTH  multiplicand (Rm, from rd1)
- b  input  WIDTH  multiplier (Rs, from rd2)
- c  input  WIDTH  accumulator (Rn), used when acc=1
- rd  input  4  destination register
- busy  output  1  high in RUN; core stalls on busy|done
- done  output  1  one-cycle pulse, result valid
- we  output  1  register-file write enable, pulses with done
- wa  output  4  destination address, held from start
- result  output  WIDTH  product (plus c), held until next accepted start
- n_flag  output  1  result[WIDTH-1], valid while done
- z_flag  output  1  result==0, valid while done

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1: latch the following at the clock edge, then go to RUN.
  - mcand=a, mplier=b
  - accum = acc ? c : 0
  - wa=rd, count=0
- RUN, each cycle:
  - if mplier[0], accum += mcand (mod 2^WIDTH)
  - mcand <<= 1; mplier >>= 1; count++
- Leave RUN for DONE after the iteration in which either condition holds:
  - count reaches WIDTH-1 (the last iteration), or
  - EARLY_TERM=1 and the shifted mplier is zero.
- At least one iteration always runs, including b=0.
- DONE: done=1 for one cycle.
  - we=1 unless wa==4'hF; PC writes are suppressed and we stays 0.
  - result = accum.
  - Next state is IDLE.
- result is the low WIDTH bits. Signed and unsigned operands give identical low bits, so there is no sign handling.
- start is ignored in RUN and DONE; it is not queued.
- Operands a/b/c/rd may change freely after the start edge.

## Timing
- Reset (async, any state), immediately:
  - state=IDLE
  - busy=0, done=0, we=0
  - wa=0, result=0, n_flag=0, z_flag=0
- Reset mid-RUN aborts the operation; no write is ever issued for it.
- Latency: start sampled at edge E0.
  - RUN covers edges E1..EN, where N = EARLY_TERM ? max(1, msb_index(b)+1) : WIDTH.
  - done/we are high for the cycle following EN.
  - The block is back in IDLE at edge EN+1.
- Throughput: a new start is accepted at the earliest in the cycle after done, i.e. sampled at edge EN+2.
- busy is high from after E0 through EN; busy and done are never high together.
- result, n_flag and z_flag are registered outputs and stable during the done cycle. result holds afterwards; n_flag and z_flag hold too but are only guaranteed while done is high.
- No combinational path exists from inputs to outputs.

## Structure
- Shared package arm_pkg:
  - mul_state_t enum {IDLE, RUN, DONE}
  - REG_PC = 4'hF, shared with the register file's r15 decode
- Single module, no sub-module.
- Iteration counter is $clog2(WIDTH) bits.
- The adder is the only WIDTH-bit arithmetic.

## Test plan
- MUL, a=7, b=6, EARLY_TERM=1 -> 3 RUN cycles; done with result=42, we=1, wa=rd, z_flag=0.
- MUL, a=b=32'hFFFFFFFF -> 32 RUN cycles; result=32'h00000001, n_flag=0. Repeat with EARLY_TERM=0 and a=5, b=3 -> 32 cycles, result=15.
- MLA, a=3, b=4, c=32'hFFFFFFF4 -> result=0, z_flag=1. MUL with b=0 -> exactly 1 RUN cycle, result=0, z_flag=1.
- start pulsed every cycle during RUN with different operands -> only the first is executed; exactly one done pulse, result unaffected.
- Reset asserted asynchronously mid-RUN (a=9, b=32'h80000000) -> all outputs 0 immediately. A following start with a=2, b=2 -> result=4.
- rd=4'hF, a=2, b=3 -> done=1, result=6, we=0.
